cdb_arbiter: RTL and testbench

- Transmitter side of the common data bus (CDB) protocol: collects completed results from NUM_FU functional units and drives the single CDB (cdb_result/cdb_tag/cdb_valid) consumed by every reservation station.
- Each FU has a small in-order result FIFO with a valid/ready handshake.
- A round-robin arbiter pops at most one result per cycle onto a registered CDB.
- Sits between the execution units and the reservation stations / register status logic.

---
 rtl/cdb_arbiter.sv | 158 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU in-order result FIFOs feeding a round-robin arbiter that
// drives a registered common data bus, at most one broadcast per cycle.
module cdb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int XLEN         = 32,
    parameter int RS_TAG_WIDTH = 3,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*XLEN-1:0]         fu_result,
    input  logic [NUM_FU*RS_TAG_WIDTH-1:0] fu_tag,
    output logic                           cdb_valid,
    output logic [XLEN-1:0]                cdb_result,
    output logic [RS_TAG_WIDTH-1:0]        cdb_tag,
    output logic [$clog2(NUM_FU)-1:0]      cdb_fu_id
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int IDW = $clog2(NUM_FU);
    localparam int SW  = IDW + 1;
    localparam logic [CW-1:0]  FULL = CW'(FIFO_DEPTH);
    localparam logic [IDW-1:0] LAST = IDW'(NUM_FU - 1);

    logic [XLEN-1:0]         data_q [NUM_FU][FIFO_DEPTH];
    logic [RS_TAG_WIDTH-1:0] tag_q  [NUM_FU][FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q [NUM_FU];
    logic [PW-1:0]           wr_ptr_d [NUM_FU];
    logic [PW-1:0]           rd_ptr_q [NUM_FU];
    logic [PW-1:0]           rd_ptr_d [NUM_FU];
    logic [CW-1:0]           count_q  [NUM_FU];
    logic [CW-1:0]           count_d  [NUM_FU];

    logic [NUM_FU-1:0]       nonempty;
    logic [NUM_FU-1:0]       push;
    logic [NUM_FU-1:0]       pop;
    logic                    grant_valid;
    logic [IDW-1:0]          grant_idx;
    logic [SW-1:0]           cand;
    logic [XLEN-1:0]         head_data;
    logic [RS_TAG_WIDTH-1:0] head_tag;

    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                    cdb_valid_q, cdb_valid_d;
    logic [XLEN-1:0]         cdb_result_q, cdb_result_d;
    logic [RS_TAG_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
    logic [IDW-1:0]          cdb_fu_id_q, cdb_fu_id_d;

    // Readiness looks only at the registered count; a same-cycle pop gives no credit.
    always_comb begin
        nonempty = '0;
        fu_ready = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            nonempty[i] = (count_q[i] != '0);
            fu_ready[i] = (count_q[i] != FULL) && !flush;
        end
    end

    // Rotating search from rr_ptr; explicit wrap keeps non-power-of-2 NUM_FU in range.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            cand = {1'b0, rr_ptr_q} + SW'(off);
            if (cand >= SW'(NUM_FU)) begin
                cand = cand - SW'(NUM_FU);
            end
            if (!grant_valid && nonempty[cand[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign head_data = data_q[grant_idx][rd_ptr_q[grant_idx]];
    assign head_tag  = tag_q[grant_idx][rd_ptr_q[grant_idx]];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            push[i] = fu_valid[i] && fu_ready[i];
            pop[i]  = grant_valid && (grant_idx == IDW'(i));
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
                count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = 1'b0;
        cdb_result_d = cdb_result_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_fu_id_d  = cdb_fu_id_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_valid) begin
            cdb_valid_d  = 1'b1;
            cdb_result_d = head_data;
            cdb_tag_d    = head_tag;
            cdb_fu_id_d  = grant_idx;
            rr_ptr_d     = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_result_q <= '0;
            cdb_tag_q    <= '0;
            cdb_fu_id_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_result_q <= cdb_result_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_fu_id_q  <= cdb_fu_id_d;
        end
    end

    // Payload storage needs no reset: counts alone decide what is live.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                data_q[i][wr_ptr_q[i]] <= fu_result[i*XLEN +: XLEN];
                tag_q[i][wr_ptr_q[i]]  <= fu_tag[i*RS_TAG_WIDTH +: RS_TAG_WIDTH];
            end
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_result = cdb_result_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_fu_id  = cdb_fu_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-FU scoreboard queues filled on accept,
// drained against every CDB broadcast, plus a NUM_FU=3 instance.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int XL = 32;
    localparam int TW = 3;
    localparam int D  = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [XL-1:0] res;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N-1:0]    fu_ready;
    logic [N*XL-1:0] fu_result;
    logic [N*TW-1:0] fu_tag;
    logic            cdb_valid;
    logic [XL-1:0]   cdb_result;
    logic [TW-1:0]   cdb_tag;
    logic [1:0]      cdb_fu_id;

    logic [2:0]      v3;
    logic [2:0]      r3;
    logic [3*XL-1:0] res3;
    logic [3*TW-1:0] tag3;
    logic            cv3;
    logic [XL-1:0]   cr3;
    logic [TW-1:0]   ct3;
    logic [1:0]      cid3;

    cdb_arbiter #(.NUM_FU(N), .XLEN(XL), .RS_TAG_WIDTH(TW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_result(fu_result), .fu_tag(fu_tag),
        .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_tag(cdb_tag), .cdb_fu_id(cdb_fu_id)
    );

    cdb_arbiter #(.NUM_FU(3), .XLEN(XL), .RS_TAG_WIDTH(TW), .FIFO_DEPTH(D)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .fu_valid(v3), .fu_ready(r3), .fu_result(res3), .fu_tag(tag3),
        .cdb_valid(cv3), .cdb_result(cr3), .cdb_tag(ct3), .cdb_fu_id(cid3)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    item_t         sb [N][$];
    int            mrr = 0;
    logic          exp_v = 1'b0;
    logic [TW-1:0] exp_tag = '0;
    logic [XL-1:0] exp_res = '0;
    logic [1:0]    exp_id = '0;
    logic [N-1:0]  acc = '0;
    int            seq [N];
    int            gcnt [N];

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [XL-1:0] r);
        fu_tag[i*TW +: TW]    = t;
        fu_result[i*XL +: XL] = r;
    endtask

    // Reference behaviour at a rising edge, using inputs as they stand before it.
    task automatic model_step();
        item_t        it;
        int           g;
        int           j;
        logic [N-1:0] rdy;
        acc = '0;
        if (!rst_n || flush) begin
            for (int i = 0; i < N; i++) sb[i].delete();
            mrr   = 0;
            exp_v = 1'b0;
            if (!rst_n) begin
                exp_tag = '0;
                exp_res = '0;
                exp_id  = '0;
            end
            return;
        end
        for (int i = 0; i < N; i++) rdy[i] = (sb[i].size() < D);
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (mrr + k) % N;
            if (g < 0 && sb[j].size() > 0) g = j;
        end
        exp_v = 1'b0;
        if (g >= 0) begin
            it      = sb[g].pop_front();
            exp_v   = 1'b1;
            exp_tag = it.tag;
            exp_res = it.res;
            exp_id  = 2'(g);
            mrr     = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (fu_valid[i] && rdy[i]) begin
                it.tag = fu_tag[i*TW +: TW];
                it.res = fu_result[i*XL +: XL];
                sb[i].push_back(it);
                acc[i] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = (sb[i].size() < D) && !flush;
        check_eq("cdb_valid", cdb_valid, exp_v);
        check_eq("cdb_tag", cdb_tag, exp_tag);
        check_eq("cdb_result", cdb_result, exp_res);
        check_eq("cdb_fu_id", cdb_fu_id, exp_id);
        check_eq("fu_ready", fu_ready, er);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        fu_valid  = '0;
        fu_result = '0;
        fu_tag    = '0;
        v3        = '0;
        for (int i = 0; i < 3; i++) begin
            tag3[i*TW +: TW] = 3'(i);
            res3[i*XL +: XL] = 32'h3000_0000 + 32'(i);
        end

        // Reset
        tick();
        tick();
        check_eq("rst_valid", cdb_valid, 0);
        check_eq("rst_tag", cdb_tag, 0);
        check_eq("rst_result", cdb_result, 0);
        check_eq("rst_fu_id", cdb_fu_id, 0);
        check_eq("rst_ready", fu_ready, 4'b1111);
        check_eq("rst3_valid", cv3, 0);
        rst_n = 1'b1;
        tick();

        // Single result, latency and hold
        set_fu(1, 3'd3, 32'hDEADBEEF);
        fu_valid = 4'b0010;
        tick();
        fu_valid = '0;
        tick();
        check_eq("single_valid", cdb_valid, 1);
        check_eq("single_tag", cdb_tag, 3);
        check_eq("single_result", cdb_result, 32'hDEADBEEF);
        check_eq("single_fu_id", cdb_fu_id, 1);
        tick();
        check_eq("single_gap", cdb_valid, 0);
        check_eq("single_hold_tag", cdb_tag, 3);
        check_eq("single_hold_res", cdb_result, 32'hDEADBEEF);

        // Reset in the middle of a burst
        for (int i = 0; i < N; i++) set_fu(i, 3'(i + 4), 32'hAAAA_0000 + 32'(i));
        fu_valid = '1;
        tick();
        tick();
        rst_n    = 1'b0;
        fu_valid = '0;
        #1;
        check_eq("rst_mid_valid", cdb_valid, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check_eq("post_rst_idle", cdb_valid, 0);
        end

        // Contention: all FUs at once, then rr_ptr wraps back to FU0
        for (int i = 0; i < N; i++) set_fu(i, 3'(i), 32'hC0DE_0000 + 32'(i));
        fu_valid = '1;
        tick();
        fu_valid = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            check_eq("cont_valid", cdb_valid, 1);
            check_eq("cont_tag", cdb_tag, k);
        end
        set_fu(0, 3'd5, 32'h5555_0000);
        set_fu(3, 3'd6, 32'h6666_0000);
        fu_valid = 4'b1001;
        tick();
        fu_valid = '0;
        tick();
        check_eq("wrap_fu0", cdb_fu_id, 0);
        tick();
        check_eq("wrap_fu3", cdb_fu_id, 3);
        tick();

        // Full contention with incrementing tags; equal grant share
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            gcnt[i] = 0;
            set_fu(i, 3'(seq[i]), (32'(i) << 16) | 32'(seq[i]));
        end
        fu_valid = '1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c >= 6 && c < 38 && cdb_valid) gcnt[cdb_fu_id]++;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    set_fu(i, 3'(seq[i]), (32'(i) << 16) | 32'(seq[i]));
                end
            end
        end
        fu_valid = '0;
        repeat (10) tick();
        for (int i = 0; i < N; i++) check_eq($sformatf("share_fu%0d", i), gcnt[i], 8);

        // Flush with three pending and a push in the flush cycle
        for (int i = 0; i < N; i++) set_fu(i, 3'(7 - i), 32'hF1F1_0000 + 32'(i));
        fu_valid = 4'b0111;
        tick();
        check_eq("pre_flush_idle", cdb_valid, 0);
        flush    = 1'b1;
        fu_valid = 4'b1000;
        tick();
        check_eq("flush_cyc_valid", cdb_valid, 0);
        check_eq("flush_cyc_ready", fu_ready, 4'b0000);
        flush    = 1'b0;
        fu_valid = '0;
        #1;
        check_eq("post_flush_ready", fu_ready, 4'b1111);
        check_eq("post_flush_valid", cdb_valid, 0);
        repeat (6) begin
            tick();
            check_eq("flush_no_bcast", cdb_valid, 0);
        end

        // Random traffic with occasional flush
        repeat (80) begin
            for (int i = 0; i < N; i++) set_fu(i, 3'($urandom), $urandom);
            fu_valid = 4'($urandom);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush    = 1'b0;
        fu_valid = '0;
        repeat (12) tick();

        // NUM_FU=3: FU0 and FU2 continuously valid
        v3 = 3'b101;
        tick();
        check_eq("nf3_first_idle", cv3, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("nf3_valid", cv3, 1);
            check_eq("nf3_fu_id", cid3, (k % 2) ? 0 : 2);
            check_eq("nf3_tag", ct3, (k % 2) ? 0 : 2);
            check_eq("nf3_result", cr3, (k % 2) ? 32'h3000_0000 : 32'h3000_0002);
            check_eq("nf3_idle_ready", r3[1], 1);
        end
        v3 = '0;
        repeat (6) tick();
        check_eq("nf3_drained", cv3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
